// File: rtl/router_pkg.sv
// Shared definitions for the VC-to-destination routing stage: FSM state
// encodings, destination codes and default geometry.
package router_pkg;

    typedef logic [1:0] state_t;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Value of the routing bit selecting each destination FIFO
    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

    // Default word geometry shared with the VC and destination FIFOs
    localparam int DATA_SIZE_DEFAULT = 6;
    localparam int DEST_BIT_DEFAULT  = 4;

endpackage

// File: rtl/vc_dest_router_if.sv
// Bus between the routing stage and its surrounding FIFOs: VC FIFO pop side,
// destination FIFO push side, and the idle indication.
// master: the router.  slave: the FIFO side (or a testbench standing in for it).
interface vc_dest_router_if #(
    parameter int DATA_SIZE = router_pkg::DATA_SIZE_DEFAULT
);
    logic                 vc0_empty;
    logic                 vc1_empty;
    logic [DATA_SIZE-1:0] vc0_data;
    logic [DATA_SIZE-1:0] vc1_data;
    logic                 pause_d0;
    logic                 pause_d1;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic                 push_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_d0;
    logic [DATA_SIZE-1:0] data_d1;
    logic                 idle;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1, idle
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data, vc1_data, pause_d0, pause_d1,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1, idle
    );
endinterface

// File: rtl/vc_dest_router_arb2.sv
// vc_arb2: two-request picker producing a one-hot grant when enabled.
// Optional feature macro: ROUTER_RR_EN -- when defined, a tie between both
// requests goes to the VC that was not popped last; otherwise VC0 always wins.
module vc_arb2
    import router_pkg::*;
(
    input  logic       en,
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

`ifdef ROUTER_RR_EN
    // Round-robin pick: on a tie prefer the VC other than the last one popped
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end
    end
`else
    // History is irrelevant under fixed priority
    logic unused_last;
    assign unused_last = last;

    // Fixed-priority pick: VC0 first, then VC1
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/vc_dest_router.sv
// vc_dest_router: pops words from two VC FIFOs, holds each for one stage and
// pushes it to destination FIFO D0 or D1 selected by word bit DEST_BIT.
// The destination pause flag stalls the whole stage (head-of-line blocking).
// Optional feature macro: ROUTER_RR_EN -- alternate VC picks when both VCs
// have data (tracked by last_q); undefined gives strict VC0 priority.
module vc_dest_router
    import router_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int DEST_BIT  = DEST_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    vc_dest_router_if.master bus
);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 src_q;
    logic [DATA_SIZE-1:0] hold_q;
    logic                 dest;
    logic                 dest_pause;
    logic                 in_hold;
    logic                 push_ok;
    logic                 pop_allowed;
    logic [1:0]           grant;
    logic                 last;

    assign in_hold    = (state_q == ST_HOLD);
    assign dest       = hold_q[DEST_BIT];
    assign dest_pause = (dest == DEST_D1) ? bus.pause_d1 : bus.pause_d0;

    // Strobes are forced low while reset is held so nothing leaks out to the
    // FIFOs before the stage is released.
    assign push_ok     = !reset && in_hold && !dest_pause;
    assign pop_allowed = !reset && ((state_q == ST_IDLE) || push_ok);

    vc_arb2 u_arb (
        .en    (pop_allowed),
        .req   ({!bus.vc1_empty, !bus.vc0_empty}),
        .last  (last),
        .grant (grant)
    );

`ifdef ROUTER_RR_EN
    logic last_q;

    // Remember which VC was popped most recently; starts at VC1 so VC0 goes first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (grant != 2'b00) begin
            last_q <= grant[1];
        end
    end

    assign last = last_q;
`else
    assign last = 1'b1;
`endif

    // Next-state: IDLE/HOLD issue pops, WAIT always lands in HOLD, pause holds HOLD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (push_ok) begin
                    state_d = (grant != 2'b00) ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Record the source VC of each pop so WAIT captures the right data bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= 1'b0;
        end else if (grant != 2'b00) begin
            src_q <= grant[1];
        end
    end

    // Capture the popped word in WAIT; it stays put until the next WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else if (state_q == ST_WAIT) begin
            hold_q <= src_q ? bus.vc1_data : bus.vc0_data;
        end
    end

    assign bus.pop_vc0 = grant[0];
    assign bus.pop_vc1 = grant[1];
    assign bus.push_d0 = push_ok && (dest == DEST_D0);
    assign bus.push_d1 = push_ok && (dest == DEST_D1);
    assign bus.data_d0 = hold_q;
    assign bus.data_d1 = hold_q;
    assign bus.idle    = (state_q == ST_IDLE) && (grant == 2'b00);

endmodule
